// File: rtl/updown_seg_counter.sv
// Up/down digit counter with prescaled tick, wrap/saturate modes, load, carry and 7-segment decode.
// Optional macro SAT_BLINK_EN: blank the display on alternate ticks while pinned at a saturation limit.
module updown_seg_counter #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 9,
  parameter int DIV     = 4,
  parameter int PW      = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             sat,
  input  logic             ini,
  input  logic [WIDTH-1:0] init_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             carry,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             e,
  output logic             f,
  output logic             g
);

  localparam logic [WIDTH-1:0] MAXV       = WIDTH'(MAX_VAL);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [WIDTH-1:0] v);
    logic [6:0] s;
    case (4'(v))
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  logic [PW-1:0]    presc;
  logic             tick_int;
  logic [WIDTH-1:0] cnt_nxt;
  logic             carry_nxt;

  assign tick_int = enable && (presc == PRESC_LAST);

  // Next count for a tick cycle; only committed when tick_int is high.
  always_comb begin
    cnt_nxt   = count;
    carry_nxt = 1'b0;
    if (up) begin
      if (count < MAXV) begin
        cnt_nxt = count + WIDTH'(1);
      end else if (!sat) begin
        cnt_nxt   = '0;
        carry_nxt = 1'b1;
      end
    end else begin
      if (count != '0) begin
        cnt_nxt = count - WIDTH'(1);
      end else if (!sat) begin
        cnt_nxt   = MAXV;
        carry_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc <= '0;
      count <= '0;
      tick  <= 1'b0;
      carry <= 1'b0;
    end else if (ini) begin
      presc <= '0;
      count <= clamp_load(init_val);
      tick  <= 1'b0;
      carry <= 1'b0;
    end else begin
      if (enable) presc <= tick_int ? '0 : presc + PW'(1);
      if (tick_int) count <= cnt_nxt;
      tick  <= tick_int;
      carry <= tick_int && carry_nxt;
    end
  end

`ifdef SAT_BLINK_EN
  logic blink;
  logic hold_lim;

  // A tick that would have stepped past a limit in saturate mode leaves the count pinned.
  assign hold_lim = sat && ((up && count >= MAXV) || (!up && count == '0));

  always_ff @(posedge clock) begin
    if (reset || ini) begin
      blink <= 1'b0;
    end else if (tick_int) begin
      blink <= hold_lim ? ~blink : 1'b0;
    end
  end

  assign {a, b, c, d, e, f, g} = blink ? 7'b0000000 : seg_decode(count);
`else
  assign {a, b, c, d, e, f, g} = seg_decode(count);
`endif

endmodule

// File: doc/updown_seg_counter.md
Name: updown_seg_counter

Overview:
- Parametrised successor to the 3-bit up/down state counter with 7-segment output.
- Generalised counter width and modulus, programmable prescaler for the count tick, wrap or saturate mode, synchronous load of an arbitrary start value, and a carry/borrow pulse for cascading digits.
- Sits under the display top level: one instance per digit, carry output driving the next digit's enable.

Parameters:
- WIDTH, 4, counter width in bits (2..4; segment decode covers 0..F).
- MAX_VAL, 9, terminal count; valid range 1..2^WIDTH-1.
- DIV, 4, prescaler period in clock cycles between count ticks; minimum 1, where 1 means a tick every enabled cycle.
- PW, 24, prescaler register width; requires DIV <= 2^PW.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- enable  in  1  prescaler advance enable; when 0, prescaler and count hold.
- up  in  1  direction: 1 = increment, 0 = decrement; sampled on the tick cycle.
- sat  in  1  mode: 1 = saturate at 0 / MAX_VAL, 0 = wrap modulo MAX_VAL+1.
- ini  in  1  synchronous load strobe.
- init_val  in  WIDTH  value loaded on ini.
- count  out  WIDTH  current count, registered.
- tick  out  1  registered one-cycle pulse, the cycle count updates.
- carry  out  1  registered one-cycle pulse on wrap (up MAX_VAL->0 or down 0->MAX_VAL).
- a,b,c,d,e,f,g  out  1 each  7-segment outputs, active-high, standard a=top, clockwise, g=middle.

Behaviour:
- Reset (reset=1 at edge): prescaler=0, count=0, tick=0, carry=0; segments show "0" (a..f=1, g=0). Reset overrides ini and enable.
- Prescaler: when enable=1, increments each cycle; at DIV-1 it returns to 0 and an internal tick_int is asserted for that cycle. When enable=0, the prescaler holds and tick_int=0.
- Count update on a tick_int cycle, taking effect at the next edge:
  - up=1, count<MAX_VAL: count+1.
  - up=1, count=MAX_VAL: sat=0 gives 0 and carry=1; sat=1 holds with carry=0.
  - up=0, count>0: count-1.
  - up=0, count=0: sat=0 gives MAX_VAL and carry=1; sat=1 holds with carry=0.
- tick register = tick_int delayed one cycle, so it is aligned with the new count value. carry is aligned the same way.
- ini=1 (no reset):
  - count loads min(init_val, MAX_VAL) at the next edge.
  - Prescaler clears to 0.
  - tick=0 and carry=0 for that cycle.
  - ini has priority over a coincident tick_int, and that tick is discarded.
- Counts above MAX_VAL are unreachable except through reset or load clamping.
- Segment decode is combinational from registered count, hex 0..F:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000.
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  - Bit order for all codes is abcdefg.
- Direction or mode changes between ticks take effect at the next tick only. No glitch pulses on tick or carry.

Optional Feature:
- Macro SAT_BLINK_EN.
- Defined: with sat=1 and count pinned at a limit (an attempted step past it occurred), a blink flag toggles on every subsequent tick_int. While the flag is 1, all segments are forced to 0. The flag clears on reset, ini, or any tick that moves the count.
- Undefined: no blink logic; segments always reflect count.

Test Plan (DIV=4, MAX_VAL=9, WIDTH=4):
- Reset asserted 3 cycles, enable=1 -> count=0, tick=carry=0, segs=1111110 during reset and first cycle after release; first tick 4 cycles after release, count=1.
- up=1, sat=0, enable=1, run 40 cycles from 0 -> count 1..9, then 0; carry=1 exactly in the cycle count becomes 0; tick period 4 cycles.
- up=0, sat=1, start at 1 -> count 0 after next tick, stays 0 on following ticks, carry never asserted; SAT_BLINK_EN build shows segments toggling all-off/"0" each tick.
- ini=1 with init_val=13 coincident with tick_int -> count=9 next cycle, tick=0, prescaler restarts: next tick 4 cycles later.
- enable=0 for 10 cycles mid-period (prescaler=2) -> count, prescaler hold; after enable=1, tick occurs after 2 more cycles.
- Reset asserted while ini=1 and tick_int=1 -> count=0, carry=0, tick=0.
